// File: rtl/sun_pll_lock_det.sv
// Lock detector for the SUN PLL: measures CK cycles per CK_REF period and
// qualifies lock against the feedback divide ratio; flags a stalled reference.
module sun_pll_lock_det #(
  parameter int DIV_N      = 32,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 2,
  parameter int CW         = 8
) (
  input  logic          i_ck,
  input  logic          i_pwrup_1v8,
  input  logic          i_ck_ref,
  output logic          o_locked,
  output logic          o_ref_lost,
  output logic [CW-1:0] o_period,
  output logic          o_period_vld
);

  // state  | meaning
  // ST_ARM | waiting for a first reference edge to start a period
  // ST_ACQ | counting consecutive good periods towards lock
  // ST_LOCK| locked; counting consecutive bad periods towards unlock
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int LO_I = (DIV_N > TOL) ? (DIV_N - TOL) : 0;
  localparam int HI_I = DIV_N + TOL;
  localparam logic [CW-1:0] LO_BND    = LO_I[CW-1:0];
  localparam logic [CW-1:0] HI_BND    = HI_I[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    LOCK_TH   = LOCK_CNT[7:0];
  localparam logic [7:0]    UNLOCK_TH = UNLOCK_CNT[7:0];

  logic          r_s1, r_s2, r_s3;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_good_cnt;
  logic [7:0]    r_bad_cnt;
  state_t        r_state;

  logic w_ref_rise;
  logic w_sat;
  logic w_good;

  assign w_ref_rise = r_s2 & ~r_s3;
  assign w_sat      = (r_cnt == CNT_MAX) && !w_ref_rise;
  assign w_good     = (r_cnt >= LO_BND) && (r_cnt <= HI_BND);

  // r_cnt holds the period so far; it is sampled as the period before reload.
  always_ff @(posedge i_ck) begin
    if (!i_pwrup_1v8) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_ck_ref;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_ref_rise) begin
        r_cnt <= CNT_ONE;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_ck) begin
    if (!i_pwrup_1v8) begin
      r_state      <= ST_ARM;
      r_good_cnt   <= 8'd0;
      r_bad_cnt    <= 8'd0;
      o_locked     <= 1'b0;
      o_ref_lost   <= 1'b0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
    end else begin
      o_period_vld <= 1'b0;
      if (w_ref_rise) begin
        o_ref_lost <= 1'b0;
        case (r_state)
          ST_ARM: begin
            r_state    <= ST_ACQ;
            r_good_cnt <= 8'd0;
          end
          ST_ACQ: begin
            o_period     <= r_cnt;
            o_period_vld <= 1'b1;
            if (w_good) begin
              r_good_cnt <= r_good_cnt + 8'd1;
              if (r_good_cnt + 8'd1 == LOCK_TH) begin
                r_state   <= ST_LOCK;
                o_locked  <= 1'b1;
                r_bad_cnt <= 8'd0;
              end
            end else begin
              r_good_cnt <= 8'd0;
            end
          end
          ST_LOCK: begin
            o_period     <= r_cnt;
            o_period_vld <= 1'b1;
            if (w_good) begin
              r_bad_cnt <= 8'd0;
            end else if (r_bad_cnt + 8'd1 == UNLOCK_TH) begin
              r_state    <= ST_ACQ;
              o_locked   <= 1'b0;
              r_good_cnt <= 8'd0;
              r_bad_cnt  <= 8'd0;
            end else begin
              r_bad_cnt <= r_bad_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_ARM;
          end
        endcase
      end else if (w_sat) begin
        r_state    <= ST_ARM;
        o_locked   <= 1'b0;
        o_ref_lost <= 1'b1;
        r_good_cnt <= 8'd0;
        r_bad_cnt  <= 8'd0;
      end
    end
  end

endmodule
